bsg_axil_csr_responder: RTL and testbench

AXI4-Lite subordinate that terminates the host-side AXI-Lite initiator with a bank of byte-strobed, read/write 32-bit-style control/status registers. It accepts write-address and write-data channels independently, commits writes, and returns B responses. It serves reads with one-cycle registered R responses. Register contents are exported flat to the accelerator side, together with per-register write pulses.

---
 rtl/bsg_axil_csr_responder.sv | 181 ++++++++++++++++++
 tb/tb_bsg_axil_csr_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_axil_csr_responder.sv
// AXI4-Lite subordinate that holds a bank of byte-strobed control/status
// registers. It has one-entry AW and W buffers, a single outstanding B
// response and a registered R response. Register contents are exported flat,
// along with a one-cycle write pulse for each register.
module bsg_axil_csr_responder #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32,
  parameter int num_regs_p   = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [addr_width_p-1:0]            awaddr_i,
  input  logic [2:0]                         awprot_i,
  input  logic                               awvalid_i,
  output logic                               awready_o,
  input  logic [data_width_p-1:0]            wdata_i,
  input  logic [data_width_p/8-1:0]          wstrb_i,
  input  logic                               wvalid_i,
  output logic                               wready_o,
  output logic [1:0]                         bresp_o,
  output logic                               bvalid_o,
  input  logic                               bready_i,
  input  logic [addr_width_p-1:0]            araddr_i,
  input  logic [2:0]                         arprot_i,
  input  logic                               arvalid_i,
  output logic                               arready_o,
  output logic [data_width_p-1:0]            rdata_o,
  output logic [1:0]                         rresp_o,
  output logic                               rvalid_o,
  input  logic                               rready_i,
  output logic [num_regs_p*data_width_p-1:0] csr_o,
  output logic [num_regs_p-1:0]              csr_wr_v_o
);

  localparam int bytes_lp    = data_width_p / 8;
  localparam int lg_bytes_lp = $clog2(bytes_lp);
  localparam int idx_w_lp    = addr_width_p - lg_bytes_lp;
  localparam int sel_w_lp    = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;
  localparam logic [idx_w_lp-1:0] num_regs_idx_lp = idx_w_lp'(num_regs_p);

  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;

  logic [data_width_p-1:0] regs_r [num_regs_p];

  logic                    aw_full_r;
  logic [idx_w_lp-1:0]     aw_idx_r;
  logic                    w_full_r;
  logic [data_width_p-1:0] w_data_r;
  logic [bytes_lp-1:0]     w_strb_r;

  logic                    bvalid_r;
  logic [1:0]              bresp_r;
  logic                    rvalid_r;
  logic [data_width_p-1:0] rdata_r;
  logic [1:0]              rresp_r;
  logic [num_regs_p-1:0]   csr_wr_v_r;
  logic [num_regs_p-1:0]   wr_dec;

  logic                    aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic                    commit;
  logic                    aw_in_range, ar_in_range;
  logic [idx_w_lp-1:0]     ar_idx;
  logic [sel_w_lp-1:0]     aw_sel, ar_sel;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{awprot_i, arprot_i,
                           awaddr_i[lg_bytes_lp-1:0], araddr_i[lg_bytes_lp-1:0]};

  assign awready_o = ~aw_full_r & ~reset_i;
  assign wready_o  = ~w_full_r & ~reset_i;
  assign arready_o = ~rvalid_r & ~reset_i;

  assign aw_hs = awvalid_i & awready_o;
  assign w_hs  = wvalid_i & wready_o;
  assign ar_hs = arvalid_i & arready_o;
  assign b_hs  = bvalid_r & bready_i;
  assign r_hs  = rvalid_r & rready_i;

  // A write commits only once both halves are buffered and the previous B
  // response has been accepted, so at most one response is ever outstanding.
  assign commit = aw_full_r & w_full_r & ~bvalid_r;

  assign ar_idx      = araddr_i[addr_width_p-1:lg_bytes_lp];
  assign aw_in_range = (aw_idx_r < num_regs_idx_lp);
  assign ar_in_range = (ar_idx < num_regs_idx_lp);
  assign aw_sel      = aw_idx_r[sel_w_lp-1:0];
  assign ar_sel      = ar_idx[sel_w_lp-1:0];

  // One-hot decode of the register being committed this cycle.
  always_comb begin
    wr_dec = '0;
    if (commit && aw_in_range)
      wr_dec[aw_sel] = 1'b1;
  end

  // AW buffer: fills on handshake, drains on commit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      aw_full_r <= 1'b0;
      aw_idx_r  <= '0;
    end else if (aw_hs) begin
      aw_full_r <= 1'b1;
      aw_idx_r  <= awaddr_i[addr_width_p-1:lg_bytes_lp];
    end else if (commit) begin
      aw_full_r <= 1'b0;
    end
  end

  // W buffer: fills on handshake, drains on commit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_full_r <= 1'b0;
      w_data_r <= '0;
      w_strb_r <= '0;
    end else if (w_hs) begin
      w_full_r <= 1'b1;
      w_data_r <= wdata_i;
      w_strb_r <= wstrb_i;
    end else if (commit) begin
      w_full_r <= 1'b0;
    end
  end

  // Register bank: byte-strobed update of the addressed register on commit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < num_regs_p; k++)
        regs_r[k] <= '0;
    end else if (commit && aw_in_range) begin
      for (int j = 0; j < bytes_lp; j++)
        if (w_strb_r[j])
          regs_r[aw_sel][j*8 +: 8] <= w_data_r[j*8 +: 8];
    end
  end

  // B channel plus the per-register write pulse that accompanies each commit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bvalid_r   <= 1'b0;
      bresp_r    <= resp_okay_lp;
      csr_wr_v_r <= '0;
    end else begin
      csr_wr_v_r <= wr_dec;
      if (commit) begin
        bvalid_r <= 1'b1;
        bresp_r  <= aw_in_range ? resp_okay_lp : resp_slverr_lp;
      end else if (b_hs) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  // R channel: capture the pre-commit register value on the AR handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rvalid_r <= 1'b0;
      rdata_r  <= '0;
      rresp_r  <= resp_okay_lp;
    end else if (ar_hs) begin
      rvalid_r <= 1'b1;
      rdata_r  <= ar_in_range ? regs_r[ar_sel] : '0;
      rresp_r  <= ar_in_range ? resp_okay_lp : resp_slverr_lp;
    end else if (r_hs) begin
      rvalid_r <= 1'b0;
    end
  end

  for (genvar k = 0; k < num_regs_p; k++) begin : g_csr
    assign csr_o[k*data_width_p +: data_width_p] = regs_r[k];
  end

  assign bvalid_o   = bvalid_r;
  assign bresp_o    = bresp_r;
  assign rvalid_o   = rvalid_r;
  assign rdata_o    = rdata_r;
  assign rresp_o    = rresp_r;
  assign csr_wr_v_o = csr_wr_v_r;

endmodule

// File: tb/tb_bsg_axil_csr_responder.sv
// Testbench for bsg_axil_csr_responder: hand-written multi-cycle sequences
// plus a table of write/read vectors, with B/R responses scored from queues.
module tb_bsg_axil_csr_responder;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [31:0]  awaddr_i;
  logic [2:0]   awprot_i;
  logic         awvalid_i;
  logic         awready_o;
  logic [31:0]  wdata_i;
  logic [3:0]   wstrb_i;
  logic         wvalid_i;
  logic         wready_o;
  logic [1:0]   bresp_o;
  logic         bvalid_o;
  logic         bready_i;
  logic [31:0]  araddr_i;
  logic [2:0]   arprot_i;
  logic         arvalid_i;
  logic         arready_o;
  logic [31:0]  rdata_o;
  logic [1:0]   rresp_o;
  logic         rvalid_o;
  logic         rready_i;
  logic [255:0] csr_o;
  logic [7:0]   csr_wr_v_o;

  bsg_axil_csr_responder #(
    .addr_width_p(32), .data_width_p(32), .num_regs_p(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .awaddr_i(awaddr_i), .awprot_i(awprot_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .araddr_i(araddr_i), .arprot_i(arprot_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .csr_o(csr_o), .csr_wr_v_o(csr_wr_v_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [31:0] model [8];
  vec_t        vecs [12];
  int          n_vec = 0;
  int          n_miss = 0;

  // Record one comparison; any difference prints a FAIL line.
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_miss++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [255:0] pack_model();
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = model[k];
    return p;
  endfunction

  function automatic logic [7:0] pulse_of(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    return (idx < 30'd8) ? (8'd1 << idx[2:0]) : 8'd0;
  endfunction

  // Scoreboard: pop and compare whenever a B or R handshake is about to occur.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (bvalid_o && bready_i) begin
        if (bq.size() == 0) fail_now("unexpected B response");
        else check("bresp", 256'(bresp_o), 256'(bq.pop_front()));
      end
      if (rvalid_o && rready_i) begin
        if (rq.size() == 0) fail_now("unexpected R response");
        else begin
          rexp_t e;
          e = rq.pop_front();
          check("rresp", 256'(rresp_o), 256'(e.resp));
          check("rdata", 256'(rdata_o), 256'(e.data));
        end
      end
    end
  end

  // Drive one write (AW and W together), then check the pulse and CSR image.
  task automatic applyStimulus(input vec_t v);
    bit aw_done, w_done, aw_hs, w_hs, found;
    if (v.wr) begin
      awaddr_i = v.addr; awvalid_i = 1'b1;
      wdata_i = v.data; wstrb_i = v.strb; wvalid_i = 1'b1;
      bq.push_back(v.resp);
      aw_done = 0; w_done = 0;
      for (int c = 0; c < 20 && !(aw_done && w_done); c++) begin
        @(negedge clk_i);
        aw_hs = awvalid_i && awready_o;
        w_hs  = wvalid_i && wready_o;
        tick();
        if (aw_hs) begin awvalid_i = 1'b0; aw_done = 1; end
        if (w_hs)  begin wvalid_i = 1'b0; w_done = 1; end
      end
      if (!(aw_done && w_done)) fail_now("write handshake");
      if (v.resp == 2'b00) model[v.addr[4:2]] = v.exp;
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk_i);
        if (bvalid_o) begin
          found = 1;
          check("csr_wr_v pulse", 256'(csr_wr_v_o), 256'(pulse_of(v.addr)));
          check("csr image", csr_o, pack_model());
        end
      end
      if (!found) fail_now("bvalid wait");
      tick();
    end else begin
      araddr_i = v.addr; arvalid_i = 1'b1;
      rq.push_back('{v.resp, v.exp});
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk_i);
        found = arvalid_i && arready_o;
        tick();
      end
      arvalid_i = 1'b0;
      if (!found) fail_now("AR handshake");
      found = 0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk_i);
        found = rvalid_o;
      end
      if (!found) fail_now("rvalid wait");
      tick();
    end
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    vecs[0]  = '{1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0};
    vecs[1]  = '{0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[2]  = '{0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEAA};
    vecs[3]  = '{1, 32'h08, 32'h11223344, 4'hA, 2'b00, 32'h11003300};
    vecs[4]  = '{0, 32'h09, 32'h0,        4'h0, 2'b00, 32'h11003300};
    vecs[5]  = '{1, 32'h1C, 32'hCAFEF00D, 4'hF, 2'b00, 32'hCAFEF00D};
    vecs[6]  = '{0, 32'h1C, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    vecs[7]  = '{1, 32'h20, 32'h55555555, 4'hF, 2'b10, 32'h0};
    vecs[8]  = '{0, 32'h20, 32'h0,        4'h0, 2'b10, 32'h0};
    vecs[9]  = '{1, 32'h00, 32'hFFFFFFFF, 4'h4, 2'b00, 32'h00FF0000};
    vecs[10] = '{0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h00FF0000};
    vecs[11] = '{0, 32'h14, 32'h0,        4'h0, 2'b00, 32'h0};
    for (int k = 0; k < 8; k++) model[k] = 32'h0;

    reset_i = 1'b1;
    awaddr_i = '0; awprot_i = 3'b101; awvalid_i = 1'b0;
    wdata_i = '0; wstrb_i = '0; wvalid_i = 1'b0; bready_i = 1'b1;
    araddr_i = '0; arprot_i = 3'b010; arvalid_i = 1'b0; rready_i = 1'b1;

    // Reset and idle state
    tick(); tick();
    @(negedge clk_i);
    checkOutput("awready in reset", 256'(awready_o), 256'(1'b0));
    checkOutput("arready in reset", 256'(arready_o), 256'(1'b0));
    tick();
    reset_i = 1'b0;
    @(negedge clk_i);
    checkOutput("idle readies", 256'({awready_o, wready_o, arready_o}), 256'(3'b111));
    checkOutput("idle valids", 256'({bvalid_o, rvalid_o}), 256'(2'b00));
    checkOutput("idle csr", csr_o, 256'(0));
    checkOutput("idle pulse", 256'(csr_wr_v_o), 256'(0));

    // AW and W in the same cycle, minimum latency
    tick();
    awaddr_i = 32'h4; awvalid_i = 1'b1;
    wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF; wvalid_i = 1'b1;
    bq.push_back(2'b00);
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("bvalid one cycle after hs", 256'(bvalid_o), 256'(1'b0));
    checkOutput("buffers full", 256'({awready_o, wready_o}), 256'(2'b00));
    tick();
    @(negedge clk_i);
    checkOutput("bvalid after commit", 256'(bvalid_o), 256'(1'b1));
    checkOutput("pulse reg1", 256'(csr_wr_v_o), 256'(8'b0000_0010));
    checkOutput("reg1 full write", 256'(csr_o[32 +: 32]), 256'(32'hDEADBEEF));
    tick();
    @(negedge clk_i);
    checkOutput("bvalid cleared", 256'(bvalid_o), 256'(1'b0));
    checkOutput("pulse one cycle", 256'(csr_wr_v_o), 256'(0));

    // W first, AW three cycles later, single byte strobe
    tick();
    wdata_i = 32'h000000AA; wstrb_i = 4'b0001; wvalid_i = 1'b1;
    tick();
    wvalid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("wready while W buffered", 256'(wready_o), 256'(1'b0));
    tick(); tick();
    awaddr_i = 32'h4; awvalid_i = 1'b1;
    bq.push_back(2'b00);
    tick();
    awvalid_i = 1'b0;
    tick();
    @(negedge clk_i);
    checkOutput("reg1 byte write", 256'(csr_o[32 +: 32]), 256'(32'hDEADBEAA));
    checkOutput("pulse reg1 late AW", 256'(csr_wr_v_o), 256'(8'b0000_0010));
    tick();
    model[1] = 32'hDEADBEAA;

    // Read with rready held low: R channel must stay stable
    rready_i = 1'b0;
    araddr_i = 32'h4; arvalid_i = 1'b1;
    rq.push_back('{2'b00, 32'hDEADBEAA});
    tick();
    arvalid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      checkOutput("R held", 256'({rvalid_o, arready_o, rresp_o, rdata_o}),
                  256'({1'b1, 1'b0, 2'b00, 32'hDEADBEAA}));
      tick();
    end
    rready_i = 1'b1;
    tick();
    @(negedge clk_i);
    checkOutput("R released", 256'({rvalid_o, arready_o}), 256'(2'b01));
    tick();

    // Table-driven writes and reads, including out-of-range addresses
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // bready low: second write stays buffered until the first B is taken
    bready_i = 1'b0;
    awaddr_i = 32'hC; awvalid_i = 1'b1;
    wdata_i = 32'h0000000A; wstrb_i = 4'hF; wvalid_i = 1'b1;
    bq.push_back(2'b00);
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    tick();
    @(negedge clk_i);
    checkOutput("first write committed", 256'({bvalid_o, csr_o[96 +: 32]}), 256'({1'b1, 32'hA}));
    tick();
    awaddr_i = 32'hC; awvalid_i = 1'b1;
    wdata_i = 32'h0000000B; wvalid_i = 1'b1;
    bq.push_back(2'b00);
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    tick(); tick();
    @(negedge clk_i);
    checkOutput("second write held", 256'({awready_o, wready_o, bvalid_o, csr_o[96 +: 32]}),
                256'({1'b0, 1'b0, 1'b1, 32'hA}));
    tick();
    bready_i = 1'b1;
    tick();
    @(negedge clk_i);
    checkOutput("bvalid gap", 256'(bvalid_o), 256'(1'b0));
    tick();
    @(negedge clk_i);
    checkOutput("second write committed", 256'({bvalid_o, csr_wr_v_o, csr_o[96 +: 32]}),
                256'({1'b1, 8'b0000_1000, 32'hB}));
    tick(); tick();

    // Reset with both buffers full drops everything
    bready_i = 1'b0;
    awaddr_i = 32'h10; awvalid_i = 1'b1;
    wdata_i = 32'h44; wvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    tick(); tick();
    awaddr_i = 32'h14; awvalid_i = 1'b1;
    wdata_i = 32'h55; wvalid_i = 1'b1;
    tick();
    awvalid_i = 1'b0; wvalid_i = 1'b0;
    tick();
    reset_i = 1'b1;
    bq.delete();
    rq.delete();
    tick();
    reset_i = 1'b0;
    bready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("post-reset state", 256'({bvalid_o, rvalid_o, awready_o, wready_o, csr_wr_v_o}),
                256'({1'b0, 1'b0, 1'b1, 1'b1, 8'h00}));
    checkOutput("post-reset csr", csr_o, 256'(0));
    tick(); tick(); tick();
    @(negedge clk_i);
    checkOutput("no commit after reset", 256'({bvalid_o, csr_o}), 256'(0));

    checkOutput("B queue drained", 256'(bq.size()), 256'(0));
    checkOutput("R queue drained", 256'(rq.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
